// File: rtl/isa_pkg.sv
// isa_pkg: shared opcode encodings, NOP word, return-address index and writeback-enable decode.
package isa_pkg;
    typedef enum logic [4:0] {
        OP_ADD = 5'd0, OP_SUB = 5'd1, OP_MUL = 5'd2, OP_DIV = 5'd3, OP_MOD = 5'd4,
        OP_CMP = 5'd5, OP_AND = 5'd6, OP_OR = 5'd7, OP_NOT = 5'd8, OP_MOV = 5'd9,
        OP_LSL = 5'd10, OP_LSR = 5'd11, OP_ASR = 5'd12, OP_NOP = 5'd13, OP_LD = 5'd14,
        OP_ST = 5'd15, OP_BEQ = 5'd16, OP_BGT = 5'd17, OP_B = 5'd18, OP_CALL = 5'd19,
        OP_RET = 5'd20
    } opcode_t;

    localparam logic [31:0] NOP_WORD = 32'h6800_0000;
    localparam logic [3:0]  RA_IDX   = 4'd15;

    function automatic logic wb_en_of(input logic [4:0] op);
        return (op <= OP_ASR && op != OP_CMP) || op == OP_LD || op == OP_CALL;
    endfunction
endpackage

// File: rtl/register_file.sv
// register_file: 16x32 flops, two write-first read ports, one write port suppressed during reset.
module register_file (
    input  logic        clk,
    input  logic        rst,
    input  logic        w_en,
    input  logic [3:0]  w_idx,
    input  logic [31:0] w_data,
    input  logic [3:0]  idx_a,
    input  logic [3:0]  idx_b,
    output logic [31:0] data_a,
    output logic [31:0] data_b
);
    logic [31:0] regs [16];
    logic        wr;

    assign wr = w_en && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else if (wr) begin
            regs[w_idx] <= w_data;
        end
    end

    assign data_a = (wr && w_idx == idx_a) ? w_data : regs[idx_a];
    assign data_b = (wr && w_idx == idx_b) ? w_data : regs[idx_b];
endmodule

// File: rtl/decode_cycle.sv
// decode_cycle: instruction decode, operand read and D/E pipeline register with
// load-use stall detection and branch/interrupt flush.
module decode_cycle
    import isa_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction_D,
    input  logic [31:0] pc_D,
    input  logic        isbranchtaken_E,
    input  logic        interrupt,
    input  logic        regwrite_W,
    input  logic [3:0]  rd_W,
    input  logic [31:0] result_W,
    output logic        add_stall,
    output logic [4:0]  opcode_E,
    output logic        isimm_E,
    output logic [31:0] op1_E,
    output logic [31:0] op2_E,
    output logic [31:0] immx_E,
    output logic [31:0] branchtarget_E,
    output logic [3:0]  rd_E,
    output logic        wb_en_E,
    output logic [31:0] pc_E
);
    logic [4:0]  op;
    logic        i_bit;
    logic [3:0]  rd, rs1, rs2, idx_a, idx_b;
    logic [1:0]  mode;
    logic [15:0] imm;
    logic [31:0] data_a, data_b, immx, target;
    logic        use_a, use_b;

    assign op    = (instruction_D[31:27] > OP_RET) ? OP_NOP : instruction_D[31:27];
    assign i_bit = instruction_D[26];
    assign rd    = instruction_D[25:22];
    assign rs1   = instruction_D[21:18];
    assign rs2   = instruction_D[17:14];
    assign mode  = instruction_D[17:16];
    assign imm   = instruction_D[15:0];

    assign idx_a = (op == OP_RET) ? RA_IDX : rs1;
    assign idx_b = (op == OP_ST) ? rd : rs2;

    // not/mov take only the second operand; branches other than ret read nothing
    assign use_a = (op <= OP_ASR && op != OP_NOT && op != OP_MOV) ||
                   op == OP_LD || op == OP_ST || op == OP_RET;
    assign use_b = (op <= OP_ASR && !i_bit) || op == OP_ST;

    assign add_stall = opcode_E == OP_LD && wb_en_E &&
                       ((use_a && idx_a == rd_E) || (use_b && idx_b == rd_E));

    always_comb begin
        immx = (mode == 2'b01) ? {16'h0, imm} :
               (mode == 2'b10) ? {imm, 16'h0} : {{16{imm[15]}}, imm};
        target = pc_D + {{3{instruction_D[26]}}, instruction_D[26:0], 2'b00};
    end

    register_file u_rf (
        .clk    (clk),
        .rst    (rst),
        .w_en   (regwrite_W),
        .w_idx  (rd_W),
        .w_data (result_W),
        .idx_a  (idx_a),
        .idx_b  (idx_b),
        .data_a (data_a),
        .data_b (data_b)
    );

    always_ff @(posedge clk) begin
        if (rst || isbranchtaken_E || interrupt || add_stall) begin
            opcode_E       <= OP_NOP;
            isimm_E        <= 1'b0;
            op1_E          <= '0;
            op2_E          <= '0;
            immx_E         <= '0;
            branchtarget_E <= '0;
            rd_E           <= '0;
            wb_en_E        <= 1'b0;
            pc_E           <= '0;
        end else begin
            opcode_E       <= op;
            isimm_E        <= i_bit;
            op1_E          <= data_a;
            op2_E          <= (i_bit && op != OP_ST) ? immx : data_b;
            immx_E         <= immx;
            branchtarget_E <= target;
            rd_E           <= (op == OP_CALL) ? RA_IDX : rd;
            wb_en_E        <= wb_en_of(op);
            pc_E           <= pc_D;
        end
    end
endmodule

// File: tb/tb_decode_cycle.sv
// tb_decode_cycle: directed self-checking bench for decode_cycle.
module tb_decode_cycle;
    logic        clk = 0;
    logic        rst;
    logic [31:0] instruction_D, pc_D, result_W;
    logic        isbranchtaken_E, interrupt, regwrite_W;
    logic [3:0]  rd_W;
    logic        add_stall, isimm_E, wb_en_E;
    logic [4:0]  opcode_E;
    logic [31:0] op1_E, op2_E, immx_E, branchtarget_E, pc_E;
    logic [3:0]  rd_E;
    int errors = 0;
    int checks = 0;

    decode_cycle dut (
        .clk(clk), .rst(rst), .instruction_D(instruction_D), .pc_D(pc_D),
        .isbranchtaken_E(isbranchtaken_E), .interrupt(interrupt),
        .regwrite_W(regwrite_W), .rd_W(rd_W), .result_W(result_W),
        .add_stall(add_stall), .opcode_E(opcode_E), .isimm_E(isimm_E),
        .op1_E(op1_E), .op2_E(op2_E), .immx_E(immx_E),
        .branchtarget_E(branchtarget_E), .rd_E(rd_E), .wb_en_E(wb_en_E), .pc_E(pc_E)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [4:0] op, input logic [3:0] rd,
                                          input logic [3:0] rs1, input logic [3:0] rs2);
        return {op, 1'b0, rd, rs1, rs2, 14'b0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [4:0] op, input logic [3:0] rd,
                                          input logic [3:0] rs1, input logic [1:0] md,
                                          input logic [15:0] imm);
        return {op, 1'b1, rd, rs1, md, imm};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wr_reg(input logic [3:0] idx, input logic [31:0] val);
        regwrite_W = 1; rd_W = idx; result_W = val;
        tick;
        regwrite_W = 0;
    endtask

    initial begin
        rst = 1; instruction_D = 32'h6800_0000; pc_D = 0; isbranchtaken_E = 0;
        interrupt = 0; regwrite_W = 0; rd_W = 0; result_W = 0;
        tick; tick;
        chk("rst_opcode", {27'b0, opcode_E}, 13);
        chk("rst_wb_en", {31'b0, wb_en_E}, 0);
        chk("rst_rd", {28'b0, rd_E}, 0);
        chk("rst_op1", op1_E, 0);
        chk("rst_pc", pc_E, 0);
        chk("rst_stall", {31'b0, add_stall}, 0);
        rst = 0;

        // bypass on write to r3 in the same cycle as decode of add r1,r3,r3
        instruction_D = enc_r(5'd0, 1, 3, 3); pc_D = 32'h40;
        regwrite_W = 1; rd_W = 3; result_W = 32'h1234;
        tick;
        regwrite_W = 0;
        chk("add_byp_op1", op1_E, 32'h1234);
        chk("add_byp_op2", op2_E, 32'h1234);
        chk("add_wb_en", {31'b0, wb_en_E}, 1);
        chk("add_rd", {28'b0, rd_E}, 1);
        chk("add_pc", pc_E, 32'h40);
        tick;
        chk("add_stored_op1", op1_E, 32'h1234);

        instruction_D = 32'h6800_0000;
        wr_reg(2, 32'h55); wr_reg(5, 32'h66); wr_reg(6, 32'h7); wr_reg(15, 32'hABC);

        // load-use stall on rs1
        instruction_D = enc_i(5'd14, 2, 6, 2'b00, 16'd4);
        tick;
        chk("ld_opcode", {27'b0, opcode_E}, 14);
        instruction_D = enc_r(5'd0, 4, 2, 5);
        #1;
        chk("lu_stall", {31'b0, add_stall}, 1);
        tick;
        chk("lu_bubble", {27'b0, opcode_E}, 13);
        chk("lu_bubble_wb", {31'b0, wb_en_E}, 0);
        chk("lu_stall_clear", {31'b0, add_stall}, 0);
        tick;
        chk("lu_retire_op", {27'b0, opcode_E}, 0);
        chk("lu_retire_op1", op1_E, 32'h55);
        chk("lu_retire_op2", op2_E, 32'h66);
        chk("lu_retire_rd", {28'b0, rd_E}, 4);

        // no stall when r2 only matches the unused rs2 field of an immediate op
        instruction_D = enc_i(5'd14, 2, 6, 2'b00, 16'd4);
        tick;
        instruction_D = enc_i(5'd0, 4, 6, 2'b00, 16'h8005);
        #1;
        chk("imm_no_stall", {31'b0, add_stall}, 0);
        tick;
        chk("imm_op1", op1_E, 32'h7);
        chk("imm_op2", op2_E, 32'hFFFF_8005);
        chk("imm_isimm", {31'b0, isimm_E}, 1);

        // branch flush
        isbranchtaken_E = 1; instruction_D = enc_r(5'd0, 1, 3, 3);
        tick;
        isbranchtaken_E = 0;
        chk("flush_opcode", {27'b0, opcode_E}, 13);
        chk("flush_wb_en", {31'b0, wb_en_E}, 0);
        interrupt = 1;
        tick;
        interrupt = 0;
        chk("irq_op1", op1_E, 0);

        // immediate extension modes
        instruction_D = enc_i(5'd9, 1, 0, 2'b00, 16'hFFFF);
        tick;
        chk("mov_sext", immx_E, 32'hFFFF_FFFF);
        chk("mov_op2", op2_E, 32'hFFFF_FFFF);
        instruction_D = enc_i(5'd9, 1, 0, 2'b01, 16'hFFFF);
        tick;
        chk("mov_zext", immx_E, 32'h0000_FFFF);
        instruction_D = enc_i(5'd9, 1, 0, 2'b10, 16'hFFFF);
        tick;
        chk("mov_hi", immx_E, 32'hFFFF_0000);

        // branch target wrap backwards
        pc_D = 32'h100; instruction_D = {5'd18, 27'h7FF_FFFF};
        tick;
        chk("b_target", branchtarget_E, 32'hFC);
        chk("b_wb_en", {31'b0, wb_en_E}, 0);
        pc_D = 32'h0; instruction_D = {5'd18, 27'h000_0001};
        tick;
        chk("b_target_fwd", branchtarget_E, 32'h4);

        // store reads rd on port B; call/ret use r15
        instruction_D = enc_i(5'd15, 3, 2, 2'b00, 16'd8);
        tick;
        chk("st_op1", op1_E, 32'h55);
        chk("st_op2", op2_E, 32'h1234);
        chk("st_immx", immx_E, 32'h8);
        chk("st_wb_en", {31'b0, wb_en_E}, 0);
        instruction_D = {5'd19, 27'h10};
        tick;
        chk("call_rd", {28'b0, rd_E}, 15);
        chk("call_wb_en", {31'b0, wb_en_E}, 1);
        instruction_D = {5'd20, 27'h0};
        tick;
        chk("ret_op1", op1_E, 32'hABC);

        // reset clears registers and suppresses a concurrent write
        rst = 1; instruction_D = enc_r(5'd0, 1, 3, 3);
        regwrite_W = 1; rd_W = 3; result_W = 32'h999;
        tick;
        chk("rst2_opcode", {27'b0, opcode_E}, 13);
        chk("rst2_op1", op1_E, 0);
        rst = 0; regwrite_W = 0;
        for (int i = 0; i < 16; i++) begin
            instruction_D = enc_r(5'd0, 0, i[3:0], i[3:0]);
            tick;
            chk($sformatf("clr_r%0d_a", i), op1_E, 0);
            chk($sformatf("clr_r%0d_b", i), op2_E, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
